// File: rtl/uart_boot_loader.sv
// UART boot loader: receives an A5-framed image over 8N1 serial and writes it
// byte-by-byte into RAM, holding the core in reset until the image is complete.
module uart_boot_loader #(
    parameter int          CLK_DIV   = 16,
    parameter logic [29:0] BASE_WORD = 30'h0,
    parameter logic [7:0]  MAGIC     = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [29:0] ram_addr,
    output logic [3:0]  ram_wstrb,
    output logic [31:0] ram_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        err
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {
        L_WAIT, L_LEN_LO, L_LEN_HI, L_DATA, L_LAST, L_DONE
    } ld_state_t;

    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;

    ld_state_t       ld_state_q, ld_state_d;
    logic [15:0]     len_q, len_d;
    logic [17:0]     n_q, n_d;
    logic [29:0]     addr_q, addr_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            hold_q, hold_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    // rx_prev_q lags the synchronized line by one clock for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (rx_state_q)
            R_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    cnt_d      = HALF;
                    rx_state_d = R_START;
                end
            end
            R_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_s2_q) begin
                    cnt_d      = FULL;
                    bit_d      = 3'd0;
                    rx_state_d = R_DATA;
                end else begin
                    rx_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    cnt_d   = FULL;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_state_d = R_STOP;
                end
            end
            R_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    byte_valid_d = rx_s2_q;
                    frame_err_d  = !rx_s2_q;
                    rx_state_d   = R_IDLE;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q   <= R_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        ld_state_d = ld_state_q;
        len_d      = len_q;
        n_d        = n_q;
        addr_d     = addr_q;
        wstrb_d    = 4'b0000;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        done_d     = done_q;
        err_d      = err_q;
        unique case (ld_state_q)
            L_WAIT: begin
                if (frame_err_q) begin
                    err_d = 1'b1;
                end else if (byte_valid_q && shift_q == MAGIC) begin
                    ld_state_d = L_LEN_LO;
                end
            end
            L_LEN_LO: begin
                if (frame_err_q) begin
                    err_d      = 1'b1;
                    ld_state_d = L_WAIT;
                end else if (byte_valid_q) begin
                    len_d[7:0] = shift_q;
                    ld_state_d = L_LEN_HI;
                end
            end
            L_LEN_HI: begin
                if (frame_err_q) begin
                    err_d      = 1'b1;
                    ld_state_d = L_WAIT;
                end else if (byte_valid_q) begin
                    len_d[15:8] = shift_q;
                    n_d         = 18'd0;
                    if ({shift_q, len_q[7:0]} == 16'd0) begin
                        hold_d     = 1'b0;
                        done_d     = 1'b1;
                        ld_state_d = L_DONE;
                    end else begin
                        ld_state_d = L_DATA;
                    end
                end
            end
            L_DATA: begin
                if (frame_err_q) begin
                    err_d      = 1'b1;
                    ld_state_d = L_WAIT;
                end else if (byte_valid_q) begin
                    addr_d  = BASE_WORD + {14'd0, n_q[17:2]};
                    wstrb_d = 4'b0001 << n_q[1:0];
                    wdata_d = {4{shift_q}};
                    n_d     = n_q + 18'd1;
                    if (n_q == {len_q, 2'b00} - 18'd1) ld_state_d = L_LAST;
                end
            end
            // last strobe is on the bus this cycle; release the core next
            L_LAST: begin
                hold_d     = 1'b0;
                done_d     = 1'b1;
                ld_state_d = L_DONE;
            end
            L_DONE: begin
                if (byte_valid_q && shift_q == MAGIC) begin
                    hold_d     = 1'b1;
                    done_d     = 1'b0;
                    ld_state_d = L_LEN_LO;
                end
            end
            default: ld_state_d = L_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_state_q <= L_WAIT;
            len_q      <= 16'd0;
            n_q        <= 18'd0;
            addr_q     <= 30'd0;
            wstrb_q    <= 4'b0000;
            wdata_q    <= 32'd0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ld_state_q <= ld_state_d;
            len_q      <= len_d;
            n_q        <= n_d;
            addr_q     <= addr_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wstrb = wstrb_q;
    assign ram_wdata = wdata_q;
    assign core_hold = hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: two instances (normal base and
// top-of-memory base) share one serial line and are checked against a byte-level model.
module tb_uart_boot_loader;

    localparam int CLK_DIV = 16;
    localparam logic [29:0] BASE0 = 30'h100;
    localparam logic [29:0] BASE1 = 30'h3FFFFFFF;

    typedef struct {
        logic [29:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        bit          last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [29:0] addr  [2];
    logic [3:0]  wstrb [2];
    logic [31:0] wdata [2];
    logic        hold  [2];
    logic        done  [2];
    logic        err   [2];

    exp_t q0[$];
    exp_t q1[$];
    bit   pend_done [2];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_boot_loader #(.CLK_DIV(CLK_DIV), .BASE_WORD(BASE0), .MAGIC(8'hA5)) dut0 (
        .clk(clk), .reset(reset), .rx(rx),
        .ram_addr(addr[0]), .ram_wstrb(wstrb[0]), .ram_wdata(wdata[0]),
        .core_hold(hold[0]), .done(done[0]), .err(err[0])
    );

    uart_boot_loader #(.CLK_DIV(CLK_DIV), .BASE_WORD(BASE1), .MAGIC(8'hA5)) dut1 (
        .clk(clk), .reset(reset), .rx(rx),
        .ram_addr(addr[1]), .ram_wstrb(wstrb[1]), .ram_wdata(wdata[1]),
        .core_hold(hold[1]), .done(done[1]), .err(err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input bit h, input bit dn, input bit e);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s dut%0d core_hold", tag, d), 32'(hold[d]), 32'(h));
            chk($sformatf("%s dut%0d done", tag, d), 32'(done[d]), 32'(dn));
            chk($sformatf("%s dut%0d err", tag, d), 32'(err[d]), 32'(e));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_state(tag, 1'b1, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s dut%0d addr", tag, d), 32'(addr[d]), 32'd0);
            chk($sformatf("%s dut%0d wstrb", tag, d), 32'(wstrb[d]), 32'd0);
            chk($sformatf("%s dut%0d wdata", tag, d), wdata[d], 32'd0);
        end
    endtask

    // Reference model: byte i of an image lands in word base+i/4, lane i%4
    task automatic expect_load(input int len, input logic [7:0] pl[$], input int nsent);
        exp_t e;
        for (int i = 0; i < nsent; i++) begin
            e.strb = 4'(1 << (i % 4));
            e.data = {4{pl[i]}};
            e.last = (i == 4 * len - 1);
            e.addr = BASE0 + 30'(i / 4);
            q0.push_back(e);
            e.addr = BASE1 + 30'(i / 4);
            q1.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   have;
        for (int d = 0; d < 2; d++) begin
            if (pend_done[d]) begin
                chk($sformatf("dut%0d done after last strobe", d), 32'(done[d]), 32'd1);
                chk($sformatf("dut%0d hold after last strobe", d), 32'(hold[d]), 32'd0);
                pend_done[d] = 1'b0;
            end
            if (wstrb[d] != 4'b0000) begin
                have = 1'b0;
                if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                if (!have) begin
                    checks++;
                    errors++;
                    $display("FAIL dut%0d unexpected strobe: got wstrb %0h addr %0h expected none",
                             d, wstrb[d], addr[d]);
                end else begin
                    chk($sformatf("dut%0d addr", d), 32'(addr[d]), 32'(e.addr));
                    chk($sformatf("dut%0d wstrb", d), 32'(wstrb[d]), 32'(e.strb));
                    chk($sformatf("dut%0d wdata", d), wdata[d], e.data);
                    chk($sformatf("dut%0d done during strobe", d), 32'(done[d]), 32'd0);
                    if (e.last) pend_done[d] = 1'b1;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop);
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = stop;
        repeat (CLK_DIV) @(negedge clk);
        rx = 1'b1;
        if (!stop) repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_image(input int len, input logic [7:0] pl[$]);
        send_byte(8'hA5, 1'b1);
        send_byte(8'(len), 1'b1);
        send_byte(8'(len >> 8), 1'b1);
        for (int i = 0; i < pl.size(); i++) send_byte(pl[i], 1'b1);
    endtask

    task automatic rand_payload(input int n, output logic [7:0] pl[$]);
        pl = {};
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0] pl[$];
        int len;
        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in the middle of a byte
        rx = 1'b0;
        repeat (CLK_DIV * 3 + 5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid-byte reset");
        rx = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * CLK_DIV) @(negedge clk);

        // Short low glitch on an idle line
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        chk_state("glitch", 1'b1, 1'b0, 1'b0);

        // Basic load
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        expect_load(1, pl, 4);
        send_image(1, pl);
        chk_state("basic load", 1'b0, 1'b1, 1'b0);

        // Preamble and empty image (restart from done)
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        chk_state("done ignores non-magic", 1'b0, 1'b1, 1'b0);
        send_byte(8'hA5, 1'b1);
        chk_state("reload magic", 1'b1, 1'b0, 1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        chk_state("empty image", 1'b0, 1'b1, 1'b0);

        // Two-word image: dut1 wraps its second word to address 0
        rand_payload(8, pl);
        expect_load(2, pl, 8);
        send_image(2, pl);
        chk_state("wrap load", 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 3; k++) begin
            len = $urandom_range(1, 3);
            rand_payload(4 * len, pl);
            expect_load(len, pl, 4 * len);
            send_image(len, pl);
            chk_state($sformatf("random load %0d", k), 1'b0, 1'b1, 1'b0);
        end

        // Framing error inside the payload
        rand_payload(8, pl);
        expect_load(2, pl, 3);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(pl[i], 1'b1);
        send_byte(pl[3], 1'b0);
        chk_state("framing error", 1'b1, 1'b0, 1'b1);
        repeat (2 * CLK_DIV) @(negedge clk);

        rand_payload(4, pl);
        expect_load(1, pl, 4);
        send_image(1, pl);
        chk_state("load after error", 1'b0, 1'b1, 1'b1);

        // Framing error while running is ignored
        send_byte(8'h5A, 1'b0);
        chk_state("error in done", 1'b0, 1'b1, 1'b1);

        repeat (4 * CLK_DIV) @(negedge clk);
        chk("dut0 pending writes", 32'(q0.size()), 32'd0);
        chk("dut1 pending writes", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
